// File: rtl/psram_req_sequencer.sv
`default_nettype none
// ============================================================================
// psram_req_sequencer: FIFO-buffered valid/ready front end that drives the
// PsramController read/write pulse + busy protocol and returns read responses.
// Revision: 1.0
// ============================================================================
module psram_req_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  output logic        timeout_err,
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [21:0]   r_fifo_addr [DEPTH];
  logic [15:0]   r_fifo_data [DEPTH];
  logic          r_fifo_wr   [DEPTH];
  logic          r_fifo_byte [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          r_op_wr;
  logic [CW-1:0] r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_timeout;
  logic [15:0]   w_wdata_fmt;
  logic [15:0]   w_rdata;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  // A pending response blocks issue so a new read can never overwrite it.
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !mem_busy && !rsp_valid;

  assign w_done    = (r_state == S_WAIT) && !mem_busy;
  assign w_timeout = (r_state == S_WAIT) && mem_busy && (r_cnt == CW'(TIMEOUT - 1));

  assign w_wdata_fmt = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
  assign w_rdata     = mem_byte_write
                     ? {8'h00, (mem_addr[0] ? mem_dout[15:8] : mem_dout[7:0])}
                     : mem_dout;

  assign idle = w_empty && (r_state == S_IDLE) && !rsp_valid;

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= req_addr;
      r_fifo_data[r_wptr] <= w_wdata_fmt;
      r_fifo_wr[r_wptr]   <= req_write;
      r_fifo_byte[r_wptr] <= req_byte;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        mem_read    = !r_op_wr;
        mem_write   = r_op_wr;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: w_state_nxt = S_WAIT;
      S_WAIT:   if (w_done || w_timeout) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr       <= '0;
      mem_din        <= '0;
      mem_byte_write <= 1'b1;
      r_op_wr        <= 1'b0;
      r_cnt          <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_error      <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      if (w_pop) begin
        mem_addr       <= r_fifo_addr[r_rptr];
        mem_din        <= r_fifo_data[r_rptr];
        mem_byte_write <= r_fifo_byte[r_rptr];
        r_op_wr        <= r_fifo_wr[r_rptr];
        r_cnt          <= '0;
      end else if ((r_state == S_SETTLE) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      if (w_done && !r_op_wr) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= w_rdata;
        rsp_error <= 1'b0;
      end

      if (w_timeout) begin
        timeout_err <= 1'b1;
        if (!r_op_wr) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_error <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psram_req_sequencer.sv
`default_nettype none
// ============================================================================
// tb_psram_req_sequencer: randomized self-checking bench with a byte-level
// memory reference model and a simple busy-driven controller model.
// Revision: 1.0
// ============================================================================
module tb_psram_req_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic        clk;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [21:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_busy;
  logic        timeout_err;
  logic        idle;

  psram_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_write(mem_byte_write), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_busy(mem_busy), .timeout_err(timeout_err),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        bw;
    logic [21:0] addr;
    logic [15:0] din;
  } pulse_t;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Controller model: each pulse starts a busy window of busy_len cycles.
  int  busy_len   = 2;
  bit  busy_stuck = 1'b0;
  bit  stick_next = 1'b0;
  int  busy_cnt   = 0;
  int  ck;
  logic [15:0] cw;
  logic [15:0] cmem [int];

  assign mem_busy = busy_stuck || (busy_cnt != 0);

  always @(posedge clk) begin
    if (mem_write || mem_read) begin
      ck = int'(mem_addr[21:1]);
      cw = cmem.exists(ck) ? cmem[ck] : 16'h0000;
      if (mem_write) begin
        if (!mem_byte_write)  cw = mem_din;
        else if (mem_addr[0]) cw[15:8] = mem_din[15:8];
        else                  cw[7:0] = mem_din[7:0];
        cmem[ck] = cw;
      end else begin
        mem_dout <= cw;
      end
      busy_cnt <= busy_len;
      if (stick_next) begin
        busy_stuck <= 1'b1;
        stick_next <= 1'b0;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Observation: pulses, response handshakes and protocol violations.
  pulse_t obs_p[$];
  rsp_t   obs_r[$];
  pulse_t exp_p[$];
  rsp_t   exp_r[$];
  int     viol = 0;
  bit     prev_rd = 1'b0;
  bit     prev_wr = 1'b0;
  time    last_pulse_t = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        obs_p.push_back({mem_write, mem_byte_write, mem_addr, mem_write ? mem_din : 16'h0000});
        last_pulse_t = $time;
      end
      if (mem_read && mem_write) viol++;
      if ((mem_read && prev_rd) || (mem_write && prev_wr)) viol++;
      prev_rd = mem_read;
      prev_wr = mem_write;
      if (rsp_valid && rsp_ready) obs_r.push_back({rsp_rdata, rsp_error});
    end
  end

  // Reference model: a flat byte memory updated in acceptance order.
  logic [7:0] bmem [int];

  function automatic logic [7:0] bget(input int a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  function automatic void model_accept(input bit wr, input bit bt,
                                       input logic [21:0] a, input logic [15:0] d);
    int ai = int'(a);
    int lo = ai & ~1;
    if (wr) begin
      if (bt) bmem[ai] = d[7:0];
      else begin
        bmem[lo]     = d[7:0];
        bmem[lo + 1] = d[15:8];
      end
      exp_p.push_back({1'b1, bt, a, bt ? {d[7:0], d[7:0]} : d});
    end else begin
      exp_p.push_back({1'b0, bt, a, 16'h0000});
      if (bt) exp_r.push_back({8'h00, bget(ai), 1'b0});
      else    exp_r.push_back({bget(lo + 1), bget(lo), 1'b0});
    end
  endfunction

  function automatic void clear_q();
    obs_p.delete(); obs_r.delete(); exp_p.delete(); exp_r.delete();
  endfunction

  bit rand_rdy = 1'b0;

  task automatic send(input bit wr, input bit bt, input logic [21:0] a, input logic [15:0] d);
    int  n  = 0;
    bit  ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_byte = bt; req_addr = a; req_wdata = d;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    while (!ok && n < 500) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        n++;
      end
    end
    if (ok) model_accept(wr, bt, a, d);
    else begin
      n_checks++; n_fail++;
      $display("FAIL send_accept: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while (!idle && n < 3000) begin @(negedge clk); n++; end
    if (!idle) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: idle=%b required 1", idle);
    end
    @(negedge clk);
  endtask

  task automatic wait_pulses(input int cnt);
    int n = 0;
    while (obs_p.size() < cnt && n < 500) begin @(negedge clk); n++; end
    if (obs_p.size() < cnt) begin
      n_checks++; n_fail++;
      $display("FAIL wait_pulses: got %0d pulses required %0d", obs_p.size(), cnt);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({mem_read, mem_write, rsp_valid, rsp_error, timeout_err, mem_byte_write} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: rd/wr/rv/re/te/bw=%b required 000001",
               {mem_read, mem_write, rsp_valid, rsp_error, timeout_err, mem_byte_write});
    end
    n_checks++;
    if (mem_addr !== 22'h0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
    n_checks++;
    if (mem_din !== 16'h0) begin n_fail++; $display("FAIL reset_din: got %h required 0", mem_din); end
    n_checks++;
    if (rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, idle} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready_idle: got %b required 11", {req_ready, idle});
    end
  endtask

  task automatic test_word_rw();
    clear_q(); busy_len = 8;
    send(1'b1, 1'b0, 22'h000010, 16'hA55A);
    send(1'b0, 1'b0, 22'h000010, 16'h0000);
    wait_idle();
    n_checks++;
    if (obs_p.size() !== 2 || obs_p[0] !== pulse_t'({1'b1, 1'b0, 22'h10, 16'hA55A})
        || obs_p[1] !== pulse_t'({1'b0, 1'b0, 22'h10, 16'h0})) begin
      n_fail++; $display("FAIL word_pulses: got %0d pulses first %h required write 10/A55A then read",
                         obs_p.size(), obs_p.size() > 0 ? obs_p[0] : pulse_t'(0));
    end
    n_checks++;
    if (obs_r.size() !== 1 || obs_r[0] !== rsp_t'({16'hA55A, 1'b0})) begin
      n_fail++; $display("FAIL word_rsp: got %0d rsp %h required 1 rsp A55A/0",
                         obs_r.size(), obs_r.size() > 0 ? obs_r[0] : rsp_t'(0));
    end
  endtask

  task automatic test_byte_odd();
    clear_q(); busy_len = 3;
    send(1'b1, 1'b1, 22'h000003, 16'h00C3);
    send(1'b0, 1'b1, 22'h000003, 16'h0000);
    wait_idle();
    n_checks++;
    if (obs_p.size() < 1 || obs_p[0] !== pulse_t'({1'b1, 1'b1, 22'h3, 16'hC3C3})) begin
      n_fail++; $display("FAIL byte_write_pulse: got %h required wr=1 bw=1 addr 3 din C3C3",
                         obs_p.size() > 0 ? obs_p[0] : pulse_t'(0));
    end
    n_checks++;
    if (obs_r.size() !== 1 || obs_r[0] !== rsp_t'({16'h00C3, 1'b0})) begin
      n_fail++; $display("FAIL byte_rsp: got %h required 00C3/0",
                         obs_r.size() > 0 ? obs_r[0] : rsp_t'(0));
    end
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    bit rdy5 = 1'b1;
    int bad = 0;
    clear_q(); busy_len = 2; busy_stuck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
      req_addr = 22'h40 + 22'(2 * i); req_wdata = 16'h1000 + 16'(i);
      @(negedge clk);
      if (i == 4) rdy5 = req_ready;
      if (req_ready) begin
        acc++;
        model_accept(1'b1, 1'b0, req_addr, req_wdata);
      end
    end
    @(posedge clk); #1; req_valid = 1'b0;
    n_checks++;
    if (acc !== DEPTH) begin n_fail++; $display("FAIL full_accepts: got %0d required %0d", acc, DEPTH); end
    n_checks++;
    if (rdy5 !== 1'b0) begin n_fail++; $display("FAIL full_ready5: got %b required 0", rdy5); end
    busy_stuck = 1'b0;
    wait_pulses(1);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b required 1", req_ready); end
    wait_idle();
    for (int i = 0; i < exp_p.size(); i++)
      if (i >= obs_p.size() || obs_p[i] !== exp_p[i]) bad++;
    n_checks++;
    if (bad != 0 || obs_p.size() != 4) begin
      n_fail++; $display("FAIL full_order: %0d of %0d pulses wrong/missing, got %0d required 4",
                         bad, exp_p.size(), obs_p.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d0;
    logic        e0;
    int np;
    int n = 0;
    bit unstable = 1'b0;
    clear_q(); busy_len = 3; rsp_ready = 1'b1;
    send(1'b1, 1'b0, 22'h20, 16'h1234);
    send(1'b1, 1'b0, 22'h22, 16'h5678);
    rsp_ready = 1'b0;
    send(1'b0, 1'b0, 22'h20, 16'h0);
    send(1'b0, 1'b1, 22'h23, 16'h0);
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    d0 = rsp_rdata; e0 = rsp_error; np = obs_p.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== d0 || rsp_error !== e0) unstable = 1'b1;
    end
    n_checks++;
    if ({d0, e0} !== {16'h1234, 1'b0}) begin n_fail++; $display("FAIL bp_first: got %h/%b required 1234/0", d0, e0); end
    n_checks++;
    if (unstable) begin n_fail++; $display("FAIL bp_hold: rsp changed during stall, required stable %h", d0); end
    n_checks++;
    if (obs_p.size() !== 3 || np !== 3) begin
      n_fail++; $display("FAIL bp_no_issue: got %0d pulses required 3", obs_p.size());
    end
    wait_idle();
    n_checks++;
    if (obs_r.size() !== 2 || obs_r[0] !== exp_r[0] || obs_r[1] !== exp_r[1]) begin
      n_fail++; $display("FAIL bp_order: got %0d rsp, second %h required %h",
                         obs_r.size(), obs_r.size() > 1 ? obs_r[1] : rsp_t'(0), exp_r[1]);
    end
  endtask

  task automatic test_random();
    int bp = 0;
    int br = 0;
    clear_q(); rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      busy_len = $urandom_range(0, 6);
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           22'($urandom_range(0, 15)), 16'($urandom));
    end
    rand_rdy = 1'b0;
    wait_idle();
    for (int i = 0; i < exp_p.size(); i++)
      if (i >= obs_p.size() || obs_p[i] !== exp_p[i]) bp++;
    for (int i = 0; i < exp_r.size(); i++)
      if (i >= obs_r.size() || obs_r[i] !== exp_r[i]) br++;
    n_checks++;
    if (bp != 0 || obs_p.size() != exp_p.size()) begin
      n_fail++; $display("FAIL rand_pulses: %0d wrong, got %0d required %0d", bp, obs_p.size(), exp_p.size());
    end
    n_checks++;
    if (br != 0 || obs_r.size() != exp_r.size()) begin
      n_fail++; $display("FAIL rand_rsp: %0d wrong, got %0d required %0d", br, obs_r.size(), exp_r.size());
    end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d violations required 0", viol); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int lat;
    clear_q(); busy_len = 2; rsp_ready = 1'b1; stick_next = 1'b1;
    send(1'b0, 1'b0, 22'h10, 16'h0);
    wait_pulses(1);
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    lat = int'(($time - last_pulse_t) / 10);
    n_checks++;
    if (lat !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d cycles required %0d", lat, TIMEOUT + 1); end
    n_checks++;
    if ({rsp_valid, rsp_rdata, rsp_error} !== {1'b1, 16'h0, 1'b1}) begin
      n_fail++; $display("FAIL to_rsp: got v=%b %h e=%b required 1 0000 1", rsp_valid, rsp_rdata, rsp_error);
    end
    n_checks++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b required 1", timeout_err); end
    send(1'b0, 1'b0, 22'h20, 16'h0);
    repeat (15) @(negedge clk);
    n_checks++;
    if (obs_p.size() !== 1) begin n_fail++; $display("FAIL to_no_issue: got %0d pulses required 1", obs_p.size()); end
    busy_stuck = 1'b0;
    wait_idle();
    n_checks++;
    if (obs_r.size() !== 2 || obs_r[1] !== exp_r[1]) begin
      n_fail++; $display("FAIL to_recover: got %0d rsp required 2 ending %h", obs_r.size(), exp_r[1]);
    end
    n_checks++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_q(); busy_len = 20; rsp_ready = 1'b1;
    send(1'b0, 1'b0, 22'h10, 16'h0);
    send(1'b0, 1'b0, 22'h12, 16'h0);
    send(1'b0, 1'b0, 22'h14, 16'h0);
    wait_pulses(1);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, rsp_valid, timeout_err} !== 4'b0000 || mem_addr !== 22'h0) begin
      n_fail++; $display("FAIL rst_async: rd/wr/rv/te=%b addr %h required 0000 and 0",
                         {mem_read, mem_write, rsp_valid, timeout_err}, mem_addr);
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, idle} !== 2'b11) begin n_fail++; $display("FAIL rst_release: got %b required 11", {req_ready, idle}); end
    n0 = obs_p.size();
    repeat (30) @(negedge clk);
    n_checks++;
    if (obs_p.size() !== n0 || obs_r.size() !== 0) begin
      n_fail++; $display("FAIL rst_stale: got %0d extra pulses %0d rsp required 0",
                         obs_p.size() - n0, obs_r.size());
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_odd();
    test_fifo_full();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/psram_req_sequencer.md
Name: psram_req_sequencer

Overview:
- Request-queueing front end that sits directly upstream of PsramController (clk domain) and converts a valid/ready request stream into the controller's single-cycle read/write pulse plus busy protocol.
- Buffers requests in a small FIFO and holds the controller's address and data stable for the whole access.
- Returns read data on a valid/ready response channel, and turns controller hangs into timeout error responses instead of deadlocks.

Parameters:
- DEPTH, 4, command FIFO depth in entries; must be a power of 2, minimum 2.
- TIMEOUT, 31, maximum cycles spent in SETTLE+WAIT before an access is aborted; must be at least 2.

Ports:
- clk  in  1  controller clock (same clock as PsramController)
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready; equals !fifo_full
- req_write  in  1  1=write, 0=read
- req_byte  in  1  1=byte access, 0=16-bit word access
- req_addr  in  22  byte address
- req_wdata  in  16  write data; byte writes use [7:0] only
- rsp_valid  out  1  read response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  16  read data
- rsp_error  out  1  response belongs to a timed-out read
- mem_read  out  1  one-cycle read pulse to the controller
- mem_write  out  1  one-cycle write pulse to the controller
- mem_byte_write  out  1  byte-write qualifier to the controller
- mem_addr  out  22  address to the controller
- mem_din  out  16  write data to the controller
- mem_dout  in  16  read data from the controller
- mem_busy  in  1  controller busy
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset
- idle  out  1  high when FIFO is empty, state is IDLE and rsp_valid=0

Behaviour:
- Reset (resetn low, async):
  - FIFO flushed.
  - State=IDLE.
  - mem_read, mem_write, rsp_valid, rsp_error, timeout_err, mem_addr, mem_din, rsp_rdata all 0.
  - mem_byte_write=1.
  - After reset: req_ready=1, idle=1.
- A reset mid-access abandons that access. No response is produced for it.
- FIFO behaviour:
  - An entry is pushed on an accept and popped on entry to ISSUE.
  - A simultaneous push and pop in the same cycle is legal, and the occupancy is unchanged.
  - When full, req_ready=0 and req_valid is ignored.
  - Read and write pointers wrap modulo DEPTH.
- State IDLE: if the FIFO is non-empty, !mem_busy and !rsp_valid, then on the next edge go to ISSUE and load the popped entry into the registered mem_addr / mem_din / mem_byte_write / op. Otherwise stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - mem_read or mem_write is high according to op.
  - Then go to SETTLE.
  - Requests are accepted in cycle N. The earliest pulse is in cycle N+2.
- State SETTLE (1 cycle): mem_busy is ignored. Then go to WAIT.
- State WAIT: on the first cycle with mem_busy=0, the access is complete.
  - Write: go to IDLE.
  - Read: rsp_rdata <= rdata, rsp_valid <= 1, rsp_error <= 0, then go to IDLE.
  - Read data selection:
    - word read: rdata=mem_dout.
    - byte read: rdata={8'h00, mem_addr[0] ? mem_dout[15:8] : mem_dout[7:0]}.
- Timeout:
  - A cycle counter clears on entry to ISSUE and increments in SETTLE and WAIT.
  - If it reaches TIMEOUT while still in WAIT with mem_busy=1, then timeout_err <= 1 and the state goes to IDLE.
  - For a read, a response is also produced with rsp_rdata=0 and rsp_error=1.
  - The next issue still waits for !mem_busy in IDLE.
- Data formatting and hold rules:
  - Byte write: mem_din={req_wdata[7:0], req_wdata[7:0]}.
  - Word write: mem_din=req_wdata.
  - mem_addr, mem_din and mem_byte_write hold their values from ISSUE until the next ISSUE.
- Response register (single entry):
  - rsp_valid stays high until rsp_ready.
  - rsp_rdata and rsp_error stay stable while rsp_valid && !rsp_ready.
  - While rsp_valid=1, IDLE does not issue, so no read can overwrite a pending response.
- Ordering and exclusivity:
  - Requests complete strictly in acceptance order.
  - mem_read and mem_write are never high together, and each is never high for 2 consecutive cycles.

Test Plan:
1. Word write then word read:
   - Stimulus: write addr 0x000010 data 0xA55A, then read 0x000010 from a model controller with busy 8 cycles.
   - Response: one mem_write pulse, then one mem_read pulse; rsp_rdata=0xA55A, rsp_error=0.
2. Byte access at an odd address:
   - Stimulus: byte write addr 0x000003 wdata 0x00C3, then byte read 0x000003.
   - Response: mem_din=0xC3C3 and mem_byte_write=1; rsp_rdata=0x00C3.
3. FIFO full:
   - Stimulus: DEPTH=4, mem_busy held high, present 5 back-to-back writes.
   - Response: 4 accepted, req_ready=0 on the 5th.
   - Then release busy: exactly 4 write pulses in order, req_ready returns to 1 after the first pop.
4. Response backpressure:
   - Stimulus: two reads queued, rsp_ready=0 for 20 cycles.
   - Response: first rsp_valid held with stable data; no second mem_read until the handshake; after rsp_ready, the second response is in order.
5. Timeout:
   - Stimulus: TIMEOUT=31, mem_busy stuck at 1 after a read issue.
   - Response: rsp_valid with rsp_error=1 and rsp_rdata=0 after 31 counted cycles; timeout_err=1 and stays 1; no new issue until busy drops.
6. Reset mid-operation:
   - Stimulus: assert resetn=0 during WAIT of a read with 2 entries queued.
   - Response: mem_read/mem_write=0 and rsp_valid=0 immediately (async); after release, idle=1, req_ready=1, and no stale pulses.
